// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the mini CPU instruction memory.
// Accepts a byte stream over valid/ready (count byte, then 16-bit words sent
// high byte first, then an optional XOR checksum byte). Each word is written to
// the IMEM write port at consecutive addresses, and the CPU is held in reset
// until a session completes cleanly.
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect a trailing checksum
// byte and report mismatches on err. Without it, err is tied low and cpu_hold
// is always released at the end of a session.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle session request, honoured only while idle
//   in_valid/in_data/in_ready  byte stream handshake
//   imem_we/imem_waddr/imem_wdata  IMEM write port, one strobe per word
//   cpu_hold        CPU reset hold, released after a successful session
//   busy            session in progress
//   done            one-cycle pulse at session end
//   err             checksum mismatch in the last session (sticky)
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word counter must hold 256 (count byte 0).
  localparam int unsigned CNT_W = 9;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_CHK, S_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_FIN
  } state_t;
`endif

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] word_cnt;
  logic [7:0]       hi_byte;
  logic             last_word;
  logic             take;
  logic             start_ok;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode from the state register.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    last_word  = (word_cnt == CNT_W'(1));
    unique case (state)
      S_IDLE: begin
        if (start) next_state = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = last_word ? S_CHK : S_HI;
`else
          next_state = last_word ? S_FIN : S_HI;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_FIN;
      end
`endif
      S_FIN: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign take     = in_valid && in_ready;
  assign start_ok = (state == S_IDLE) && start;

  // Word assembly, write port, address counter, hold and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt   <= '0;
      hi_byte    <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      done    <= (next_state == S_FIN);
      // Address advances at the end of the write cycle, so the strobe
      // sees a stable address for its whole cycle.
      if (imem_we) begin
        imem_waddr <= imem_waddr + ADDR_W'(1);
      end
      if (take) begin
        unique case (state)
          S_LEN: begin
            word_cnt <= (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);
          end
          S_HI: begin
            hi_byte <= in_data;
          end
          S_LO: begin
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, in_data};
            word_cnt   <= word_cnt - CNT_W'(1);
          end
          default: begin
          end
        endcase
      end
      // err is already final in FIN, so the hold drops one cycle later.
      if (state == S_FIN) begin
        cpu_hold <= err;
      end
      if (start_ok) begin
        imem_waddr <= '0;
        cpu_hold   <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of data bytes; compared against the trailing checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_ok) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (take) begin
      if ((state == S_HI) || (state == S_LO)) begin
        csum <= csum ^ in_data;
      end else if (state == S_CHK) begin
        err <= (in_data != csum);
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// Drives inputs and samples outputs on the falling clock edge; a write
// monitor logs every IMEM strobe and done pulse for later comparison.
// Adapts to the IMEM_LOADER_CHECKSUM_EN build option.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [15:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Write / done monitor.
  logic [ADDR_W-1:0] wr_addr [0:1023];
  logic [15:0]       wr_data [0:1023];
  int wr_n   = 0;
  int done_n = 0;

  always @(negedge clk) begin
    if (imem_we && (wr_n < 1024)) begin
      wr_addr[wr_n] = imem_waddr;
      wr_data[wr_n] = imem_wdata;
      wr_n = wr_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns on the falling edge
  // right after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; !in_ready; n++) begin
      if (n >= 20) begin
        check("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 3));
    return 0;
  endfunction

  // Session 02 12 34 AB 05 [88 or 00].
  task automatic load(input int mode, input bit bad);
    logic exp_err;
    int   w0;
    int   d0;
    exp_err = CS & bad;
    w0 = wr_n;
    d0 = done_n;
    pulse_start();
    check("start_busy",  32'(busy),     32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_err",   32'(err),      32'd0);
    check("start_hold",  32'(cpu_hold), 32'd1);
    send_byte(8'h02, gap_for(mode));
    send_byte(8'h12, gap_for(mode));
    send_byte(8'h34, gap_for(mode));
    check("w0_we",   32'(imem_we),    32'd1);
    check("w0_addr", 32'(imem_waddr), 32'd0);
    check("w0_data", 32'(imem_wdata), 32'h1234);
    send_byte(8'hAB, gap_for(mode));
    send_byte(8'h05, gap_for(mode));
    check("w1_we",   32'(imem_we),    32'd1);
    check("w1_addr", 32'(imem_waddr), 32'd1);
    check("w1_data", 32'(imem_wdata), 32'hAB05);
    if (CS) send_byte(bad ? 8'h00 : 8'h88, gap_for(mode));
    check("fin_done", 32'(done),     32'd1);
    check("fin_err",  32'(err),      32'(exp_err));
    check("fin_busy", 32'(busy),     32'd1);
    check("fin_hold", 32'(cpu_hold), 32'd1);
    tick();
    check("post_done",  32'(done),     32'd0);
    check("post_busy",  32'(busy),     32'd0);
    check("post_ready", 32'(in_ready), 32'd0);
    check("post_hold",  32'(cpu_hold), 32'(exp_err));
    check("n_writes",   32'(wr_n - w0),   32'd2);
    check("n_done",     32'(done_n - d0), 32'd1);
    check("log_a0", 32'(wr_addr[w0]),     32'd0);
    check("log_d0", 32'(wr_data[w0]),     32'h1234);
    check("log_a1", 32'(wr_addr[w0 + 1]), 32'd1);
    check("log_d1", 32'(wr_data[w0 + 1]), 32'hAB05);
    repeat (2) tick();
    check("sticky_err",  32'(err),      32'(exp_err));
    check("sticky_hold", 32'(cpu_hold), 32'(exp_err));
  endtask

  // Count byte 0: 256 words with data {i, i^C3}.
  task automatic load_256();
    logic [7:0] cs;
    logic [7:0] hi;
    logic [7:0] lo;
    int w0;
    w0 = wr_n;
    cs = 8'h00;
    pulse_start();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'hC3;
      cs = cs ^ hi ^ lo;
      send_byte(hi, 0);
      send_byte(lo, 0);
    end
    if (CS) send_byte(cs, 0);
    check("c0_done", 32'(done), 32'd1);
    check("c0_err",  32'(err),  32'd0);
    tick();
    check("c0_hold",    32'(cpu_hold),  32'd0);
    check("c0_nwrites", 32'(wr_n - w0), 32'd256);
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'hC3;
      check("c0_word", {8'h00, 8'(wr_addr[w0 + i]), wr_data[w0 + i]},
            {8'h00, hi, hi, lo});
    end
  endtask

  task automatic mid_session();
    int w1;
    // start while in HI must not restart the session.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_busy",  32'(busy),     32'd1);
    check("mid_ready", 32'(in_ready), 32'd1);
    send_byte(8'hAB, 0);
    send_byte(8'h05, 0);
    check("mid_addr", 32'(imem_waddr), 32'd1);
    check("mid_data", 32'(imem_wdata), 32'hAB05);
    if (CS) send_byte(8'h88, 0);
    check("mid_done", 32'(done), 32'd1);
    check("mid_err",  32'(err),  32'd0);
    tick();
    check("mid_hold", 32'(cpu_hold), 32'd0);

    // Reset after the first word of a new session.
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    tick();
    w1 = wr_n;
    in_valid = 1'b1;
    in_data  = 8'hAB;
    rst = 1'b1;
    #1;
    check("arst_hold",  32'(cpu_hold), 32'd1);
    check("arst_busy",  32'(busy),     32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_we",    32'(imem_we),  32'd0);
    check("arst_addr",  32'(imem_waddr), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    in_data = 8'h05;
    repeat (4) tick();
    check("arst_idle_ready", 32'(in_ready), 32'd0);
    check("arst_nwrites",    32'(wr_n - w1), 32'd0);
    check("arst_idle_hold",  32'(cpu_hold), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_hold",  32'(cpu_hold),   32'd1);
    check("rst_ready", 32'(in_ready),   32'd0);
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_addr",  32'(imem_waddr), 32'd0);
    check("rst_data",  32'(imem_wdata), 32'd0);
    rst = 1'b0;

    // Idle with in_valid high: nothing is consumed.
    in_valid = 1'b1;
    in_data  = 8'h02;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_we",    32'(imem_we),  32'd0);
      check("idle_hold",  32'(cpu_hold), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("idle_nwrites", 32'(wr_n), 32'd0);
    check("idle_ndone",   32'(done_n), 32'd0);

    load(0, 1'b0);
    load(0, 1'b1);
    load(0, 1'b0);
    load(1, 1'b0);
    load(2, 1'b0);
    load_256();
    mid_session();
    load(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
